// File: rtl/clock_div_pkg.sv
// Shared types and constants for the clock divider controller.
package clock_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   localparam int MIN_MOD         = 2;
   localparam int DEFAULT_MOD_VAL = 6;

endpackage

// File: rtl/mod_counter.sv
// Modulo counter: count register, increment and terminal-count compare.
module mod_counter #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic [WIDTH-1:0] mod,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);

   logic [WIDTH-1:0] mod_m1;

   assign mod_m1 = mod - WIDTH'(1);
   // >= rather than == so a shrunken modulus recovers on the next edge
   assign wrap   = run && (count >= mod_m1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (!run || wrap) begin
         count <= '0;
      end else begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/clock_div_ctrl.sv
// Programmable clock divider with modulus handshake.
// Optional feature: define CLOCK_DIV_CTRL_PERIOD_CNT_EN to add the 8-bit period_cnt output.
module clock_div_ctrl
   import clock_div_pkg::*;
#(
   parameter int WIDTH       = 3,
   parameter int DEFAULT_MOD = clock_div_pkg::DEFAULT_MOD_VAL
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] mod_in,
   input  logic             mod_valid,
   output logic             mod_ready,
   output logic [WIDTH-1:0] count,
   output logic             tick,
   output logic             out,
   output logic             busy
`ifdef CLOCK_DIV_CTRL_PERIOD_CNT_EN
   ,
   output logic [7:0]       period_cnt
`endif
);

   state_t           state;
   logic [WIDTH-1:0] active_mod;
   logic [WIDTH-1:0] pend_mod;
   logic [WIDTH-1:0] mod_clamped;
   logic             xfer;
   logic             run;
   logic             wrap;

   function automatic logic [WIDTH-1:0] clamp_mod(input logic [WIDTH-1:0] m);
      return (m < WIDTH'(MIN_MOD)) ? WIDTH'(MIN_MOD) : m;
   endfunction

   assign mod_ready   = (state != PEND);
   assign busy        = (state != IDLE);
   assign xfer        = mod_valid && mod_ready;
   assign mod_clamped = clamp_mod(mod_in);
   assign run         = (state != IDLE) && en;

   mod_counter #(
      .WIDTH (WIDTH)
   ) u_mod_counter (
      .clk   (clk),
      .reset (reset),
      .run   (run),
      .mod   (active_mod),
      .count (count),
      .wrap  (wrap)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         active_mod <= WIDTH'(DEFAULT_MOD);
         pend_mod   <= '0;
         tick       <= 1'b0;
         out        <= 1'b0;
      end else begin
         tick <= wrap;
         out  <= out ^ wrap;
         case (state)
            IDLE: begin
               if (xfer) begin
                  active_mod <= mod_clamped;
               end
               if (en) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (!en) begin
                  state <= IDLE;
                  if (xfer) begin
                     active_mod <= mod_clamped;
                  end
               end else if (xfer) begin
                  // On the wrap edge the new modulus governs the period just starting
                  if (wrap) begin
                     active_mod <= mod_clamped;
                  end else begin
                     pend_mod <= mod_clamped;
                     state    <= PEND;
                  end
               end
            end
            PEND: begin
               if (!en) begin
                  active_mod <= pend_mod;
                  pend_mod   <= '0;
                  state      <= IDLE;
               end else if (wrap) begin
                  active_mod <= pend_mod;
                  pend_mod   <= '0;
                  state      <= RUN;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef CLOCK_DIV_CTRL_PERIOD_CNT_EN
   // Counts alongside tick (updated on the same edge that raises it)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         period_cnt <= 8'd0;
      end else if ((state != IDLE) && !en) begin
         period_cnt <= 8'd0;
      end else if (wrap) begin
         period_cnt <= period_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Directed self-checking bench for clock_div_ctrl (WIDTH=3, DEFAULT_MOD=6).
module tb_clock_div_ctrl;

   logic       clk;
   logic       reset;
   logic       en;
   logic [2:0] mod_in;
   logic       mod_valid;
   logic       mod_ready;
   logic [2:0] count;
   logic       tick;
   logic       out;
   logic       busy;
`ifdef CLOCK_DIV_CTRL_PERIOD_CNT_EN
   logic [7:0] period_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   clock_div_ctrl #(
      .WIDTH       (3),
      .DEFAULT_MOD (6)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .mod_in    (mod_in),
      .mod_valid (mod_valid),
      .mod_ready (mod_ready),
      .count     (count),
      .tick      (tick),
      .out       (out),
      .busy      (busy)
`ifdef CLOCK_DIV_CTRL_PERIOD_CNT_EN
      ,
      .period_cnt (period_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      reset     = 1'b1;
      en        = 1'b0;
      mod_in    = 3'd0;
      mod_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("rst_count", count, 0);
      chk("rst_tick", tick, 0);
      chk("rst_out", out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", mod_ready, 1);
      cyc(2);
      reset = 1'b1;
      en    = 1'b1;

      // default modulus 6
      cyc(1);
      chk("run_busy", busy, 1);
      chk("run_count0", count, 0);
      for (int i = 1; i <= 5; i++) begin
         cyc(1);
         chk("m6_count", count, i);
         chk("m6_tick", tick, 0);
      end
      cyc(1);
      chk("m6_wrap_count", count, 0);
      chk("m6_wrap_tick", tick, 1);
      chk("m6_wrap_out", out, 1);
      cyc(6);
      chk("m6_2nd_tick", tick, 1);
      chk("m6_2nd_out", out, 0);

      // load 4 at count 1 -> pending until wrap
      cyc(1);
      chk("ld4_count1", count, 1);
      mod_in    = 3'd4;
      mod_valid = 1'b1;
      cyc(1);
      mod_valid = 1'b0;
      chk("pend_ready", mod_ready, 0);
      chk("pend_busy", busy, 1);
      chk("pend_count", count, 2);
      for (int i = 3; i <= 5; i++) begin
         cyc(1);
         chk("pend_cnt", count, i);
         chk("pend_ready_hold", mod_ready, 0);
      end
      cyc(1);
      chk("ld4_wrap_tick", tick, 1);
      chk("ld4_wrap_out", out, 1);
      chk("ld4_ready", mod_ready, 1);
      for (int i = 1; i <= 3; i++) begin
         cyc(1);
         chk("m4_count", count, i);
         chk("m4_tick", tick, 0);
      end
      cyc(1);
      chk("m4_wrap_tick", tick, 1);
      chk("m4_wrap_out", out, 0);
      cyc(4);
      chk("m4_2nd_tick", tick, 1);
      chk("m4_2nd_out", out, 1);

      // en=0 at count 3
      cyc(3);
      chk("stop_count3", count, 3);
      en = 1'b0;
      cyc(1);
      chk("stop_count", count, 0);
      chk("stop_busy", busy, 0);
      chk("stop_out", out, 1);
      chk("stop_tick", tick, 0);
      cyc(1);
      chk("idle_count", count, 0);
      chk("idle_tick", tick, 0);
      en = 1'b1;
      cyc(1);
      chk("restart_busy", busy, 1);
      chk("restart_count", count, 0);
      cyc(1);
      chk("restart_count1", count, 1);

      // load 1 in IDLE -> clamped to 2
      en = 1'b0;
      cyc(1);
      chk("idle2_busy", busy, 0);
      mod_in    = 3'd1;
      mod_valid = 1'b1;
      cyc(1);
      mod_valid = 1'b0;
      en        = 1'b1;
      cyc(1);
      chk("m2_count0", count, 0);
      cyc(1);
      chk("m2_count1", count, 1);
      chk("m2_tick_lo", tick, 0);
      cyc(1);
      chk("m2_wrap_count", count, 0);
      chk("m2_wrap_tick", tick, 1);
      chk("m2_wrap_out", out, 0);
      cyc(1);
      chk("m2_tick_lo2", tick, 0);
      cyc(1);
      chk("m2_tick2", tick, 1);
      chk("m2_out2", out, 1);

      // reset mid-cycle while pending 3
      mod_in    = 3'd3;
      mod_valid = 1'b1;
      cyc(1);
      mod_valid = 1'b0;
      chk("p3_ready", mod_ready, 0);
      chk("p3_count", count, 1);
      #2 reset = 1'b0;
      #1;
      chk("mrst_count", count, 0);
      chk("mrst_tick", tick, 0);
      chk("mrst_out", out, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_ready", mod_ready, 1);
      reset = 1'b1;
      cyc(1);
      chk("post_busy", busy, 1);
      chk("post_count", count, 0);
      chk("post_ready", mod_ready, 1);
      for (int i = 1; i <= 5; i++) begin
         cyc(1);
         chk("post_m6_count", count, i);
      end
      cyc(1);
      chk("post_wrap_tick", tick, 1);
      chk("post_wrap_out", out, 1);

      // load 3 on the wrap cycle -> takes effect immediately, stays RUN
      cyc(5);
      chk("wl_count5", count, 5);
      mod_in    = 3'd3;
      mod_valid = 1'b1;
      chk("wl_ready_pre", mod_ready, 1);
      cyc(1);
      mod_valid = 1'b0;
      chk("wl_count", count, 0);
      chk("wl_tick", tick, 1);
      chk("wl_ready", mod_ready, 1);
      cyc(2);
      chk("m3_count2", count, 2);
      cyc(1);
      chk("m3_wrap_count", count, 0);
      chk("m3_wrap_tick", tick, 1);
      chk("m3_wrap_out", out, 1);

`ifdef CLOCK_DIV_CTRL_PERIOD_CNT_EN
      en = 1'b0;
      cyc(1);
      chk("pc_idle", period_cnt, 0);
      mod_in    = 3'd2;
      mod_valid = 1'b1;
      cyc(1);
      mod_valid = 1'b0;
      en        = 1'b1;
      cyc(1);
      chk("pc_start", period_cnt, 0);
      cyc(520);
      chk("pc_520", period_cnt, 4);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
